rom_load_ctrl: RTL and testbench
================================

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024, core-reset hold time after download end, in clk_sys cycles.
REQ-002 SHALL have port clk_sys  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ioctl_download in 1, ioctl_index in 8, ioctl_wr in 1, ioctl_addr in 25, ioctl_dout in 8: HPS download stream.
REQ-005 SHALL have port ioctl_wait  out  1  stall to HPS while a download write is pending.
REQ-006 SHALL have ports core_req in 1, core_we in 1, core_addr in 18, core_din in 8: core-side memory requester.
REQ-007 SHALL have ports core_ack out 1, core_dout out 8: one-cycle grant/read-data strobe.
REQ-008 SHALL have ports mem_addr out 18, mem_din out 8, mem_we out 1, mem_dout in 8: shared memory port, fixed 1-cycle read latency.
REQ-009 SHALL have ports mod_id out 8, dip_sw out 64, core_reset out 1.

Function
REQ-010 SHALL implement states IDLE, DL, SETTLE, RUN.
REQ-011 SHALL go IDLE->DL when ioctl_download=1 and ioctl_index=0; DL->SETTLE on ioctl_download falling; SETTLE->RUN after exactly SETTLE_CYCLES cycles; RUN->DL on new index-0 download.
REQ-012 SHALL drive core_reset=1 in IDLE, DL, SETTLE; 0 only in RUN.
REQ-013 SHALL capture ioctl_wr with index 0 and ioctl_addr<0x30000 into a one-entry pending latch (addr[17:0], data).
REQ-014 SHALL drop index-0 writes with ioctl_addr>=0x30000 (no mem_we, no wait).
REQ-015 SHALL issue a pending download write on mem_* the cycle after capture unless the port is granted to core that cycle; then on the following cycle.
REQ-016 SHALL assert ioctl_wait combinationally while the latch is full; a second ioctl_wr while full SHALL be ignored (HPS contract).
REQ-017 SHALL give download writes strict priority over core requests.
REQ-018 SHALL grant core_req only in RUN and only when no download write is pending; grant lasts one cycle.
REQ-019 SHALL, on core grant with core_we=1, drive mem_we=1, mem_addr=core_addr, mem_din=core_din, and pulse core_ack the same cycle.
REQ-020 SHALL, on core grant with core_we=0, drive mem_we=0, and pulse core_ack one cycle later with core_dout=mem_dout.
REQ-021 SHALL hold core_req requesters unacked (core_ack=0) in IDLE, DL, SETTLE; request held until ack.
REQ-022 SHALL load mod_id from ioctl_dout on ioctl_wr with ioctl_index=1 (any address, last write wins), in any state.
REQ-023 SHALL load dip_sw byte ioctl_addr[2:0] (byte n -> bits 8n+7:8n) on ioctl_wr with ioctl_index=254 and ioctl_addr[24:3]=0, in any state.
REQ-024 SHALL count SETTLE from 0 to SETTLE_CYCLES-1 and restart the count if ioctl_download rises (index 0) during SETTLE, returning to DL.
REQ-025 SHALL drive mem_we=0 on every cycle with no issued write.

Reset
REQ-026 SHALL, while reset_n=0, force state IDLE, latch empty, ioctl_wait=0, core_ack=0, mem_we=0, mem_addr=0, mem_din=0, core_dout=0, mod_id=8'hFF, dip_sw=0, core_reset=1, settle count 0.
REQ-027 SHALL, on reset assertion mid-download, discard any pending write; on release, stay IDLE until next index-0 download rises.

Verification
REQ-028 Download 4 bytes index 0 at 0x00000..0x00003 -> four mem_we pulses, matching addr/data, ioctl_wait never high with no core traffic.
REQ-029 Write at 0x30000 -> no mem_we, ioctl_wait=0.
REQ-030 Download end, SETTLE_CYCLES=16 -> core_reset falls exactly 16 cycles after ioctl_download falls.
REQ-031 RUN, core read 0x10005 -> core_ack 1 cycle after grant, core_dout=mem_dout; simultaneous core_req and download write -> download first, core acked next cycle.
REQ-032 Index 254 writes 0x01@0, 0xA5@7 -> dip_sw=64'hA500_0000_0000_0001; index 1 write 0x03 -> mod_id=3.
REQ-033 reset_n low during DL with pending write -> mem_we=0, ioctl_wait=0, core_reset=1, mod_id=FF.

Source files
------------

// File: rtl/rom_load_ctrl_if.sv
// Bus bundle for rom_load_ctrl. It carries the HPS download stream, the core requester and the shared memory port.
// The master side is the surrounding system. The slave side is the controller.
interface rom_load_ctrl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  logic        core_req;
  logic        core_we;
  logic [17:0] core_addr;
  logic [7:0]  core_din;
  logic        core_ack;
  logic [7:0]  core_dout;

  logic [17:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    output core_req, core_we, core_addr, core_din,
    input  core_ack, core_dout,
    input  mem_addr, mem_din, mem_we,
    output mem_dout
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    input  core_req, core_we, core_addr, core_din,
    output core_ack, core_dout,
    output mem_addr, mem_din, mem_we,
    input  mem_dout
  );
endinterface

// File: rtl/rom_load_ctrl.sv
// ROM download controller. Index-0 HPS writes reach memory one cycle after capture, with priority over the core.
// The core gets the port one cycle after its request. Reads are acked one cycle later. ioctl_wait stalls HPS while a captured write is blocked.
module rom_load_ctrl #(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  rom_load_ctrl_if.slave bus,
  output logic [7:0]     mod_id,
  output logic [63:0]    dip_sw,
  output logic           core_reset
);

  typedef enum logic [1:0] {S_IDLE, S_DL, S_SETTLE, S_RUN} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        dl_q;
  logic        pend_q, pend_d;
  logic [17:0] pend_addr_q;
  logic [7:0]  pend_dat_q;
  logic        gnt_q, gnt_d;
  logic        rd_ack_q, rd_ack_d;
  logic [7:0]  mod_id_q;
  logic [63:0] dip_sw_q;

  logic idx0, dl_rise, dl_fall, cap, issue, wait_w, cfg_id, cfg_dip;

  assign idx0    = (bus.ioctl_index == 8'd0);
  assign dl_rise = bus.ioctl_download && !dl_q && idx0;
  assign dl_fall = !bus.ioctl_download && dl_q;

  // Held writes wait only while the core owns the port. An issuing latch may be refilled in the same cycle.
  assign issue   = pend_q && !gnt_q;
  assign wait_w  = pend_q && gnt_q;
  assign cap     = bus.ioctl_wr && idx0 && (bus.ioctl_addr < 25'h003_0000) && !wait_w;
  assign pend_d  = cap || (pend_q && !issue);

  assign cfg_id  = bus.ioctl_wr && (bus.ioctl_index == 8'd1);
  assign cfg_dip = bus.ioctl_wr && (bus.ioctl_index == 8'd254) && (bus.ioctl_addr[24:3] == 22'd0);

  assign bus.ioctl_wait = wait_w;
  assign mod_id         = mod_id_q;
  assign dip_sw         = dip_sw_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (dl_rise) state_d = S_DL;
      S_DL:     if (dl_fall) state_d = S_SETTLE;
      S_SETTLE: begin
        if (dl_rise)                state_d = S_DL;
        else if (cnt_q == CNT_LAST) state_d = S_RUN;
      end
      S_RUN:    if (dl_rise) state_d = S_DL;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = (state_q == S_SETTLE && state_d == S_SETTLE) ? cnt_q + CW'(1) : '0;
  end

  always_comb begin
    core_reset = (state_q != S_RUN);
    // A grant is withheld while a download write is still owed the port, including one captured this cycle.
    gnt_d      = (state_d == S_RUN) && bus.core_req && !gnt_q && !rd_ack_q && !pend_d;
    rd_ack_d   = gnt_q && !bus.core_we;

    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (gnt_q) begin
      bus.mem_we   = bus.core_we;
      bus.mem_addr = bus.core_addr;
      bus.mem_din  = bus.core_din;
    end else if (pend_q) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = pend_addr_q;
      bus.mem_din  = pend_dat_q;
    end

    bus.core_ack  = (gnt_q && bus.core_we) || rd_ack_q;
    bus.core_dout = rd_ack_q ? bus.mem_dout : 8'h00;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      // Reset to 1 so that a download still held high across reset is not taken as a new start.
      dl_q        <= 1'b1;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
      gnt_q       <= 1'b0;
      rd_ack_q    <= 1'b0;
      mod_id_q    <= 8'hFF;
      dip_sw_q    <= '0;
    end else begin
      dl_q     <= bus.ioctl_download;
      pend_q   <= pend_d;
      gnt_q    <= gnt_d;
      rd_ack_q <= rd_ack_d;
      if (cap) begin
        pend_addr_q <= bus.ioctl_addr[17:0];
        pend_dat_q  <= bus.ioctl_dout;
      end
      if (cfg_id)  mod_id_q <= bus.ioctl_dout;
      if (cfg_dip) dip_sw_q[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl.
// It covers a config-write vector table, hand-built timing sequences, and random traffic checked against a byte-image memory model.
module tb_rom_load_ctrl;
  localparam int SETTLE = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [7:0]  mod_id;
  logic [63:0] dip_sw;
  logic        core_reset;

  rom_load_ctrl_if bus();

  rom_load_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .mod_id     (mod_id),
    .dip_sw     (dip_sw),
    .core_reset (core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  bit [7:0]    env_mem [0:262143];
  bit [7:0]    ref_mem [0:262143];
  int          wr_cnt   = 0;
  int          wait_cnt = 0;
  logic [25:0] wr_log[$];

  // Shared memory: one-cycle registered read.
  always @(posedge clk_sys) begin
    bus.mem_dout <= env_mem[bus.mem_addr];
    if (bus.mem_we === 1'b1) env_mem[bus.mem_addr] = bus.mem_din;
  end

  always @(negedge clk_sys) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      wr_log.push_back({bus.mem_addr, bus.mem_din});
    end
    if (bus.ioctl_wait === 1'b1) wait_cnt++;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic hps_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    tick();
    bus.ioctl_wr    = 1'b0;
    bus.ioctl_index = 8'd0;
  endtask

  task automatic core_txn(input logic we, input logic [17:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    bus.core_req  = 1'b1;
    bus.core_we   = we;
    bus.core_addr = a;
    bus.core_din  = d;
    rd  = 8'h00;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (bus.core_ack === 1'b1) begin
        lat = c;
        rd  = bus.core_dout;
        break;
      end
      tick();
    end
    tick();
    bus.core_req = 1'b0;
  endtask

  function automatic logic [24:0] rnd_addr();
    logic [24:0] base;
    case ($urandom_range(0, 3))
      0:       base = 25'h000_0000;
      1:       base = 25'h001_0000;
      2:       base = 25'h002_FFF8;
      default: base = 25'h003_0000;
    endcase
    return 25'(base + $urandom_range(0, 15));
  endfunction

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dat;
    logic        exp_we;
    logic [17:0] exp_maddr;
    logic [7:0]  exp_mod;
    logic [63:0] exp_dip;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rd;
    logic [25:0] e;
    logic [24:0] ha;
    logic [17:0] ca;
    logic [7:0]  exp_mod;
    int          lat, cnt, w0, wait0;

    vt[0]  = '{8'd254, 25'h0000000, 8'h01, 1'b0, 18'h0,     8'hFF, 64'h0000_0000_0000_0001};
    vt[1]  = '{8'd254, 25'h0000007, 8'hA5, 1'b0, 18'h0,     8'hFF, 64'hA500_0000_0000_0001};
    vt[2]  = '{8'd1,   25'h0001234, 8'h03, 1'b0, 18'h0,     8'h03, 64'hA500_0000_0000_0001};
    vt[3]  = '{8'd254, 25'h0000008, 8'h77, 1'b0, 18'h0,     8'h03, 64'hA500_0000_0000_0001};
    vt[4]  = '{8'd254, 25'h0000003, 8'h5A, 1'b0, 18'h0,     8'h03, 64'hA500_0000_5A00_0001};
    vt[5]  = '{8'd0,   25'h0000005, 8'h11, 1'b1, 18'h00005, 8'h03, 64'hA500_0000_5A00_0001};
    vt[6]  = '{8'd0,   25'h002FFFF, 8'h22, 1'b1, 18'h2FFFF, 8'h03, 64'hA500_0000_5A00_0001};
    vt[7]  = '{8'd0,   25'h0030000, 8'h33, 1'b0, 18'h0,     8'h03, 64'hA500_0000_5A00_0001};
    vt[8]  = '{8'd0,   25'h1000004, 8'h44, 1'b0, 18'h0,     8'h03, 64'hA500_0000_5A00_0001};
    vt[9]  = '{8'd7,   25'h0000000, 8'h55, 1'b0, 18'h0,     8'h03, 64'hA500_0000_5A00_0001};
    vt[10] = '{8'd1,   25'h0000000, 8'h7E, 1'b0, 18'h0,     8'h7E, 64'hA500_0000_5A00_0001};

    reset_n = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_din = '0;

    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst core_reset", core_reset, 1);
    chk("rst mod_id", mod_id, 8'hFF);
    chk("rst dip_sw", dip_sw, 0);
    chk("rst mem_we", bus.mem_we, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_din", bus.mem_din, 0);
    chk("rst ioctl_wait", bus.ioctl_wait, 0);
    chk("rst core_ack", bus.core_ack, 0);
    chk("rst core_dout", bus.core_dout, 0);
    tick();
    reset_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_index = vt[i].idx;
      bus.ioctl_addr = vt[i].addr; bus.ioctl_dout = vt[i].dat;
      @(negedge clk_sys);
      chk($sformatf("vec%0d ioctl_wait", i), bus.ioctl_wait, 0);
      tick();
      bus.ioctl_wr = 1'b0; bus.ioctl_index = 8'd0;
      @(negedge clk_sys);
      chk($sformatf("vec%0d mem_we", i), bus.mem_we, vt[i].exp_we);
      if (vt[i].exp_we) begin
        chk($sformatf("vec%0d mem_addr", i), bus.mem_addr, vt[i].exp_maddr);
        chk($sformatf("vec%0d mem_din", i), bus.mem_din, vt[i].dat);
        ref_mem[vt[i].exp_maddr] = vt[i].dat;
      end
      chk($sformatf("vec%0d mod_id", i), mod_id, vt[i].exp_mod);
      chk($sformatf("vec%0d dip_sw", i), dip_sw, vt[i].exp_dip);
      chk($sformatf("vec%0d core_reset", i), core_reset, 1);
      tick();
    end
    exp_mod = 8'h7E;

    // Four-byte download with no core traffic.
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0;
    tick();
    wr_log.delete();
    wait0 = wait_cnt;
    for (int i = 0; i < 4; i++) hps_wr(8'd0, 25'(i), 8'(8'hC0 + i));
    tick(); tick();
    chk("dl4 write count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      e = {18'(i), 8'(8'hC0 + i)};
      if (i < wr_log.size()) chk($sformatf("dl4 write%0d", i), wr_log[i], e);
      ref_mem[18'(i)] = 8'(8'hC0 + i);
    end
    chk("dl4 ioctl_wait cycles", wait_cnt - wait0, 0);

    // A fresh download during SETTLE restarts the hold count.
    bus.ioctl_download = 1'b0;
    repeat (5) tick();
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_download = 1'b0;
    cnt = 0;
    for (int k = 0; k < SETTLE; k++) begin
      tick();
      @(negedge clk_sys);
      if (core_reset === 1'b1) cnt++;
    end
    chk("settle core_reset high cycles", cnt, SETTLE);
    tick();
    @(negedge clk_sys);
    chk("settle core_reset released", core_reset, 0);

    // Core read: grant next cycle, ack with data one cycle after grant.
    env_mem[18'h10005] = 8'h6C; ref_mem[18'h10005] = 8'h6C;
    tick();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 18'h10005;
    @(negedge clk_sys);
    chk("rd req-cycle ack", bus.core_ack, 0);
    tick();
    @(negedge clk_sys);
    chk("rd grant mem_addr", bus.mem_addr, 18'h10005);
    chk("rd grant mem_we", bus.mem_we, 0);
    chk("rd grant ack", bus.core_ack, 0);
    tick();
    @(negedge clk_sys);
    chk("rd ack", bus.core_ack, 1);
    chk("rd core_dout", bus.core_dout, 8'h6C);
    tick();
    bus.core_req = 1'b0;
    tick();

    // Core write and download write in the same cycle: the download write goes first.
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 18'h00100; bus.core_din = 8'h99;
    bus.ioctl_wr = 1'b1; bus.ioctl_index = 8'd0; bus.ioctl_addr = 25'h200; bus.ioctl_dout = 8'h98;
    @(negedge clk_sys);
    chk("sim cyc0 ack", bus.core_ack, 0);
    tick();
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("sim cyc1 mem_we", bus.mem_we, 1);
    chk("sim cyc1 mem_addr", bus.mem_addr, 18'h00200);
    chk("sim cyc1 mem_din", bus.mem_din, 8'h98);
    chk("sim cyc1 ack", bus.core_ack, 0);
    tick();
    @(negedge clk_sys);
    chk("sim cyc2 mem_addr", bus.mem_addr, 18'h00100);
    chk("sim cyc2 mem_din", bus.mem_din, 8'h99);
    chk("sim cyc2 ack", bus.core_ack, 1);
    tick();
    bus.core_req = 1'b0;
    ref_mem[18'h00200] = 8'h98; ref_mem[18'h00100] = 8'h99;
    tick();

    // Random traffic against the byte-image model.
    wait0 = wait_cnt;
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      ha = rnd_addr();
      ca = ha[17:0];
      if (op <= 3) begin
        if ($urandom_range(0, 7) == 0) ha = ha | 25'h100_0000;
        e[7:0] = 8'($urandom);
        hps_wr(8'd0, ha, e[7:0]);
        if (ha < 25'h003_0000) ref_mem[ha[17:0]] = e[7:0];
      end else if (op == 4) begin
        e[7:0] = 8'($urandom);
        hps_wr(8'd1, ha, e[7:0]);
        exp_mod = e[7:0];
      end else if (op <= 6) begin
        e[7:0] = 8'($urandom);
        core_txn(1'b1, ca, e[7:0], rd, lat);
        chk($sformatf("rnd%0d wr latency", n), lat, 1);
        ref_mem[ca] = e[7:0];
      end else begin
        core_txn(1'b0, ca, 8'h00, rd, lat);
        chk($sformatf("rnd%0d rd latency", n), lat, 2);
        chk($sformatf("rnd%0d rd data @%0h", n, ca), rd, ref_mem[ca]);
      end
    end
    tick();
    @(negedge clk_sys);
    chk("rnd mod_id", mod_id, exp_mod);
    chk("rnd ioctl_wait cycles", wait_cnt - wait0, 0);

    // Reset while a download write is pending.
    tick();
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0;
    tick();
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h50; bus.ioctl_dout = 8'hEE;
    tick();
    bus.ioctl_wr = 1'b0;
    reset_n = 1'b0;
    #1;
    w0 = wr_cnt;
    @(negedge clk_sys);
    chk("mid-rst mem_we", bus.mem_we, 0);
    chk("mid-rst ioctl_wait", bus.ioctl_wait, 0);
    chk("mid-rst core_reset", core_reset, 1);
    chk("mid-rst mod_id", mod_id, 8'hFF);
    chk("mid-rst dip_sw", dip_sw, 0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    bus.ioctl_download = 1'b0;
    cnt = 0;
    for (int k = 0; k < SETTLE + 8; k++) begin
      tick();
      @(negedge clk_sys);
      if (core_reset !== 1'b1) cnt++;
    end
    chk("post-rst idle core_reset low cycles", cnt, 0);
    chk("post-rst discarded writes", wr_cnt - w0, 0);
    tick();
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_download = 1'b0;
    repeat (SETTLE + 1) tick();
    @(negedge clk_sys);
    chk("post-rst run core_reset", core_reset, 0);
    tick();
    core_txn(1'b0, 18'h00050, 8'h00, rd, lat);
    chk("post-rst rd latency", lat, 2);
    chk("post-rst rd data", rd, ref_mem[18'h00050]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
